// File: rtl/quiz3_pkg.sv
// Shared types and default constants for the quiz3 binary entry checker.
package quiz3_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  localparam int N_DIGITS_DEF    = 5;
  localparam int THRESHOLD_DEF   = 3;
  localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Synchronizer chain plus falling-edge detector for one active-low button.
module btn_sync_edge
  import quiz3_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   last_q, last_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], btn_n};
    last_d = sync_q[SYNC_STAGES-1];
  end

  // All flops reset to the released level so no spurious press follows reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '1;
      last_q <= 1'b1;
    end else begin
      sync_q <= sync_d;
      last_q <= last_d;
    end
  end

  assign press = last_q & ~sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/quiz3.sv
// Five-digit binary entry checker: collects digits from two buttons and lights
// the LED on entry when enough of the collected digits are 1.
module quiz3
  import quiz3_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter int THRESHOLD   = THRESHOLD_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn0,
  input  logic btn1,
  input  logic btnEntry,
  output logic ledLight
);

  localparam int CW = $clog2(N_DIGITS + 1);
  localparam logic [CW-1:0] N_CW = CW'(N_DIGITS);
  localparam int unsigned TH_U = THRESHOLD;

  function automatic logic [CW-1:0] popcount(input logic [N_DIGITS-1:0] v);
    logic [CW-1:0] s;
    s = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      s = s + CW'(v[i]);
    end
    return s;
  endfunction

  logic ev0, ev1, ev_entry;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync0 (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn0),
    .press (ev0)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync1 (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btn1),
    .press (ev1)
  );

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_entry (
    .clk   (clk),
    .rst   (rst),
    .btn_n (btnEntry),
    .press (ev_entry)
  );

  state_e                state_q, state_d;
  logic [N_DIGITS-1:0]   code_q, code_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  led_q, led_d;
  logic                  digit_ev;
  logic [CW-1:0]         ones;

  // Simultaneous 0 and 1 presses cancel each other out.
  assign digit_ev = ev0 ^ ev1;
  assign ones     = popcount(code_q);

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    led_d   = led_q;
    if (ev_entry) begin
      // Entry wins over a same-cycle digit; the digit is dropped.
      led_d   = (cnt_q == N_CW) && (32'(ones) >= TH_U);
      code_d  = '0;
      cnt_d   = '0;
      state_d = COLLECT;
    end else if (state_q == COLLECT && digit_ev) begin
      code_d = {code_q[N_DIGITS-2:0], ev1};
      cnt_d  = cnt_q + CW'(1);
      if (cnt_d == N_CW) begin
        state_d = FULL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      code_q  <= '0;
      cnt_q   <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      cnt_q   <= cnt_d;
      led_q   <= led_d;
    end
  end

  assign ledLight = led_q;

endmodule

// File: tb/tb_quiz3.sv
// Self-checking bench for quiz3: queue-based reference model compared every
// cycle, plus directed sequences with hand-computed LED values.
module tb_quiz3;

  localparam int N  = 5;
  localparam int TH = 3;
  localparam int S  = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn0 = 1'b1;
  logic btn1 = 1'b1;
  logic btnEntry = 1'b1;
  logic ledLight;

  always #5 clk = ~clk;

  quiz3 #(.N_DIGITS(N), .THRESHOLD(TH), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .btn0     (btn0),
    .btn1     (btn1),
    .btnEntry (btnEntry),
    .ledLight (ledLight)
  );

  int checks = 0;
  int passes = 0;
  bit started = 0;

  // Raw button samples per rising edge; index 0 is the newest.
  bit h0 [0:S+1];
  bit h1 [0:S+1];
  bit he [0:S+1];
  bit m_q[$];
  bit m_led = 0;
  bit e0, e1, ee;
  int ones;

  initial begin
    for (int i = 0; i <= S + 1; i++) begin
      h0[i] = 1; h1[i] = 1; he[i] = 1;
    end
  end

  // Reference: a press takes effect S edges after its first low sample.
  always @(posedge clk) begin
    for (int i = S + 1; i > 0; i--) begin
      h0[i] = h0[i-1]; h1[i] = h1[i-1]; he[i] = he[i-1];
    end
    h0[0] = btn0; h1[0] = btn1; he[0] = btnEntry;
    if (rst) begin
      for (int i = 0; i <= S + 1; i++) begin
        h0[i] = 1; h1[i] = 1; he[i] = 1;
      end
      m_q.delete();
      m_led = 0;
    end else begin
      e0 = !h0[S] && h0[S+1];
      e1 = !h1[S] && h1[S+1];
      ee = !he[S] && he[S+1];
      if (ee) begin
        ones = 0;
        foreach (m_q[i]) ones += int'(m_q[i]);
        m_led = (m_q.size() == N) && (ones >= TH);
        m_q.delete();
      end else if ((e0 ^ e1) && m_q.size() < N) begin
        m_q.push_back(e1);
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      checks++;
      if (ledLight === m_led) passes++;
      else $display("FAIL led_cycle t=%0t got %b want %b", $time, ledLight, m_led);
    end
  end

  task automatic check_lit(input string name, input bit exp);
    checks++;
    if (ledLight === exp && m_led == exp) passes++;
    else $display("FAIL %s: dut %b model %b want %b", name, ledLight, m_led, exp);
  endtask

  task automatic press(input bit b0, input bit b1, input bit be, input int lo, input int hi);
    btn0 = !b0; btn1 = !b1; btnEntry = !be;
    repeat (lo) @(negedge clk);
    btn0 = 1; btn1 = 1; btnEntry = 1;
    repeat (hi) @(negedge clk);
  endtask

  task automatic digit(input bit v);
    press(!v, v, 0, $urandom_range(1, 2), $urandom_range(1, 2));
  endtask

  task automatic digits(input logic [15:0] seq, input int n);
    for (int i = n - 1; i >= 0; i--) digit(seq[i]);
  endtask

  task automatic entry_check(input string name, input bit exp);
    press(0, 0, 1, 1, 1);
    repeat (3) @(negedge clk);
    check_lit(name, exp);
  endtask

  task automatic do_reset();
    rst = 1;
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 0;
    started = 1;
    check_lit("reset_state", 0);

    digits(16'b01011, 5); entry_check("p01011", 1);
    digits(16'b00001, 5); entry_check("p00001", 0);
    digits(16'b11110, 5); entry_check("p11110", 1);
    digits(16'b10100, 5); entry_check("p10100", 0);
    digits(16'b11111, 5); entry_check("p11111", 1);
    digits(16'b111, 3);   entry_check("short_entry", 0);
    digits(16'b11000, 5); entry_check("cleared_buffer", 0);
    digits(16'b1111100, 7); entry_check("full_ignores_extra", 1);
    press(1, 1, 0, 1, 1);
    digits(16'b11100, 5); entry_check("collision_no_digit", 1);

    // Entry and digit in the same cycle: entry sees 4 digits, digit dropped.
    digits(16'b1111, 4);
    press(0, 1, 1, 1, 1);
    repeat (3) @(negedge clk);
    check_lit("entry_with_digit", 0);
    digits(16'b11100, 5); entry_check("after_entry_digit", 1);

    digits(16'b00000, 5); entry_check("p00000", 0);
    digits(16'b11100, 5); entry_check("light_before_rst", 1);
    digits(16'b10, 2);
    do_reset();
    @(negedge clk);
    check_lit("rst_clears_led", 0);
    digits(16'b00111, 5); entry_check("after_rst", 1);

    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 49);
      if (r == 0) do_reset();
      else if (r < 18) press(1, 0, 0, $urandom_range(1, 3), $urandom_range(1, 3));
      else if (r < 36) press(0, 1, 0, $urandom_range(1, 3), $urandom_range(1, 3));
      else if (r < 42) press(0, 0, 1, $urandom_range(1, 3), $urandom_range(1, 3));
      else press(1'($urandom), 1'($urandom), 1'($urandom), $urandom_range(1, 3), $urandom_range(1, 3));
    end
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
